// File: rtl/db_cbf_fetch_pkg.sv
// Shared geometry constants and FSM encoding for the deblocking CBF reader.
package db_cbf_fetch_pkg;

  localparam int CBF_ROW_NUM  = 16;
  localparam int CBF_ADR_W    = 6;
  localparam int CBF_BANK_W   = 2;
  localparam int CBF_WORD_W   = 16;
  localparam int CBF_ROW_W    = CBF_ADR_W - CBF_BANK_W;
  localparam int CBF_EDGE_NUM = CBF_WORD_W / 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } cbf_state_e;

  // RAM address of a 4x4 row inside a bank.
  function automatic logic [CBF_ADR_W-1:0] cbf_adr(input logic [CBF_BANK_W-1:0] bank,
                                                   input logic [CBF_ROW_W-1:0]  row);
    return {bank, row};
  endfunction

endpackage

// File: rtl/db_cbf_edge_map.sv
// Combinational map from one CBF row word (plus neighbours) to the P/Q cbf
// pairs of the 8x8-grid vertical and horizontal edges crossing that row.
module db_cbf_edge_map
  import db_cbf_fetch_pkg::*;
(
  input  logic [CBF_WORD_W-1:0]   cur_i,
  input  logic [CBF_WORD_W-1:0]   prev_i,
  input  logic [CBF_WORD_W-1:0]   top_i,
  input  logic                    left_bit_i,
  input  logic                    first_row_i,
  input  logic                    even_row_i,
  input  logic                    left_en_i,
  input  logic                    top_en_i,
  output logic [CBF_EDGE_NUM-1:0] ver_p_o,
  output logic [CBF_EDGE_NUM-1:0] ver_q_o,
  output logic                    hor_vld_o,
  output logic [CBF_WORD_W-1:0]   hor_p_o,
  output logic [CBF_WORD_W-1:0]   hor_q_o
);

  // Vertical edge k sits on column 2k: P is the column to its left, Q the column itself.
  // Edge 0 is the LCU boundary, whose P side comes from the left neighbour LCU.
  genvar gi;
  generate
    for (gi = 0; gi < CBF_EDGE_NUM; gi++) begin : g_ver
      if (gi == 0) begin : g_left
        assign ver_p_o[gi] = left_bit_i & left_en_i;
        assign ver_q_o[gi] = cur_i[0] & left_en_i;
      end else begin : g_inner
        assign ver_p_o[gi] = cur_i[2*gi-1];
        assign ver_q_o[gi] = cur_i[2*gi];
      end
    end
  endgenerate

  assign hor_vld_o = even_row_i;

  // Horizontal edges exist only on even rows; row 0 pairs against the LCU above.
  always_comb begin
    hor_p_o = '0;
    hor_q_o = '0;
    if (even_row_i) begin
      if (first_row_i) begin
        if (top_en_i) begin
          hor_p_o = top_i;
          hor_q_o = cur_i;
        end
      end else begin
        hor_p_o = prev_i;
        hor_q_o = cur_i;
      end
    end
  end

endmodule

// File: rtl/db_cbf_fetch.sv
// Reader engine for the deblocking CBF buffer: scans one LCU bank row by row
// and hands per-row edge cbf pairs to the boundary-strength logic.
// Optional boundary-availability inputs are enabled by defining DB_CBF_AVAIL_EN.
module db_cbf_fetch
  import db_cbf_fetch_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [CBF_BANK_W-1:0]   lcu_sel_i,
  input  logic [CBF_WORD_W-1:0]   left_cbf_i,
  input  logic [CBF_WORD_W-1:0]   top_cbf_i,
`ifdef DB_CBF_AVAIL_EN
  input  logic                    left_avail_i,
  input  logic                    top_avail_i,
`endif
  output logic                    cen_o,
  output logic                    wen_o,
  output logic [CBF_ADR_W-1:0]    adr_o,
  input  logic [CBF_WORD_W-1:0]   rd_dat_i,
  output logic                    row_vld_o,
  input  logic                    row_rdy_i,
  output logic [CBF_ROW_W-1:0]    row_idx_o,
  output logic [CBF_EDGE_NUM-1:0] ver_p_o,
  output logic [CBF_EDGE_NUM-1:0] ver_q_o,
  output logic                    hor_vld_o,
  output logic [CBF_WORD_W-1:0]   hor_p_o,
  output logic [CBF_WORD_W-1:0]   hor_q_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam logic [CBF_ROW_W-1:0] LAST_ROW = CBF_ROW_W'(CBF_ROW_NUM - 1);

  cbf_state_e              state_q, state_d;
  logic [CBF_ROW_W-1:0]    row_q, row_d;
  logic [CBF_BANK_W-1:0]   bank_q, bank_d;
  logic [CBF_WORD_W-1:0]   left_q, left_d;
  logic [CBF_WORD_W-1:0]   top_q, top_d;
  logic [CBF_WORD_W-1:0]   cur_q, cur_d;
  logic [CBF_WORD_W-1:0]   prev_q, prev_d;
  logic [CBF_ADR_W-1:0]    adr_q, adr_d;
  logic                    left_en, top_en;
  logic                    map_hor_vld;

`ifdef DB_CBF_AVAIL_EN
  logic left_avail_q, top_avail_q;

  // Availability flags are captured with the rest of the boundary context on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_avail_q <= 1'b0;
      top_avail_q  <= 1'b0;
    end else if (state_q == ST_IDLE && start_i) begin
      left_avail_q <= left_avail_i;
      top_avail_q  <= top_avail_i;
    end
  end

  assign left_en = left_avail_q;
  assign top_en  = top_avail_q;
`else
  assign left_en = 1'b1;
  assign top_en  = 1'b1;
`endif

  // State, row counter and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      bank_q  <= '0;
      left_q  <= '0;
      top_q   <= '0;
      cur_q   <= '0;
      prev_q  <= '0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      bank_q  <= bank_d;
      left_q  <= left_d;
      top_q   <= top_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      adr_q   <= adr_d;
    end
  end

  // Next-state logic; the address register is loaded on entry to RD so it
  // keeps its last value in every other state.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    bank_d  = bank_q;
    left_d  = left_q;
    top_d   = top_q;
    cur_d   = cur_q;
    prev_d  = prev_q;
    adr_d   = adr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          bank_d  = lcu_sel_i;
          left_d  = left_cbf_i;
          top_d   = top_cbf_i;
          row_d   = '0;
          adr_d   = cbf_adr(lcu_sel_i, '0);
          state_d = ST_RD;
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP: begin
        cur_d   = rd_dat_i;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (row_rdy_i) begin
          prev_d = cur_q;
          if (row_q == LAST_ROW) begin
            state_d = ST_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            adr_d   = cbf_adr(bank_q, row_q + 1'b1);
            state_d = ST_RD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  db_cbf_edge_map u_edge_map (
    .cur_i       (cur_q),
    .prev_i      (prev_q),
    .top_i       (top_q),
    .left_bit_i  (left_q[row_q]),
    .first_row_i (row_q == '0),
    .even_row_i  (~row_q[0]),
    .left_en_i   (left_en),
    .top_en_i    (top_en),
    .ver_p_o     (ver_p_o),
    .ver_q_o     (ver_q_o),
    .hor_vld_o   (map_hor_vld),
    .hor_p_o     (hor_p_o),
    .hor_q_o     (hor_q_o)
  );

  assign cen_o     = (state_q != ST_RD);
  assign wen_o     = 1'b1;
  assign adr_o     = adr_q;
  assign row_vld_o = (state_q == ST_OUT);
  assign row_idx_o = row_q;
  // Held low while idle so the block looks fully cleared out of reset.
  assign hor_vld_o = map_hor_vld & busy_o;
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);

endmodule

// File: doc/db_cbf_fetch.md
# db_cbf_fetch

Reader engine for the deblocking coded-block-flag buffer. It scans one 64x64 LCU bank of a 64-word x 16-bit single-port CBF RAM row by row, one word per 4x4 row, where bit c is the cbf of 4x4 column c. For each row it delivers P/Q cbf pairs for the 8x8-grid vertical and horizontal edges to the boundary-strength logic over a valid/ready handshake.

## Interface
Parameters:
- none (geometry is fixed by shared constants)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- start_i  in  1  pulse: begin LCU scan; ignored unless idle
- lcu_sel_i  in  2  bank select, sampled on accepted start
- left_cbf_i  in  16  left-LCU right-most column cbf, bit r = row r; sampled on start
- top_cbf_i  in  16  above-LCU bottom row cbf, bit c = column c; sampled on start
- cen_o  out  1  RAM chip enable, low active
- wen_o  out  1  RAM write enable, low active; constant 1
- adr_o  out  6  RAM address {bank[1:0], row[3:0]}
- rd_dat_i  in  16  RAM read data, valid the cycle after cen_o low
- row_vld_o  out  1  edge data valid
- row_rdy_i  in  1  consumer ready
- row_idx_o  out  4  current 4x4 row
- ver_p_o / ver_q_o  out  8 each  vertical edge k (column 2k): P = bit 2k-1 (k=0: left_cbf[r]), Q = bit 2k
- hor_vld_o  out  1  row carries horizontal edges (row even)
- hor_p_o / hor_q_o  out  16 each  P = previous row word (row 0: top_cbf), Q = current word; zero on odd rows
- busy_o  out  1  scan in progress
- done_o  out  1  one-cycle pulse at scan end

## Operation
- FSM states are IDLE, RD, CAP, OUT and DONE.
- IDLE: when start_i=1, latch bank, left and top inputs; set row to 0; go to RD.
- RD: drive cen_o=0 and adr_o={bank,row}; go to CAP.
- CAP: register rd_dat_i into cur; go to OUT.
- OUT: drive row_vld_o=1. On row_vld_o & row_rdy_i, copy cur into prev. If row=15, go to DONE; otherwise increment row and go to RD.
- DONE: drive done_o=1; go to IDLE.
- In every state other than RD, cen_o=1 and adr_o holds its last value.
- The RAM is never written.
- busy_o=1 in all states except IDLE.
- Outputs are combinational from the cur, prev, left and top registers. They change only on state or row updates.

## Timing
- Reset values: row_vld_o=0, done_o=0, busy_o=0, cen_o=1, wen_o=1, adr_o=0. All data outputs and internal registers are 0. State is IDLE.
- Start accepted at edge E0: RD is cycle 1, CAP is cycle 2, first row_vld_o is cycle 3.
- Minimum of 3 cycles per row. With row_rdy_i held at 1, rows appear at cycles 3, 6, …, 48, and done_o is high in cycle 49.
- While row_rdy_i=0, all outputs hold stable.
- start_i during busy_o=1 is ignored, including in the DONE cycle.
- Reset asserted mid-scan returns the block to IDLE immediately with the reset values above. No partial done_o is produced.
- Row wrap: no carry beyond row 15; the bank bits never change during a scan.

## Configuration
- DB_CBF_AVAIL_EN defined:
  - Adds inputs left_avail_i and top_avail_i (1 bit each), sampled on start.
  - left_avail_i=0 forces ver_p_o[0] and ver_q_o[0] to 0 on every row.
  - top_avail_i=0 forces hor_p_o and hor_q_o to 0 on row 0, with hor_vld_o still 1.
- DB_CBF_AVAIL_EN undefined: the ports are absent and boundary edges always use left_cbf_i and top_cbf_i.

## Structure
- Shared defines in the common encoder defines file:
  - CBF_ROW_NUM=16
  - CBF_ADR_W=6
  - CBF_BANK_W=2
  - CBF_WORD_W=16
  - FSM state encodings (3-bit)
- Sub-module db_cbf_edge_map: purely combinational; maps cur, prev, left bit, top word and row parity to the ver/hor P/Q vectors. The top level holds the FSM, counters and registers.

## Test plan
- Bank 2, RAM rows hold 16'hA5A5 ^ row, left_cbf=16'hFFFF, top_cbf=16'h0000, rdy always 1:
  - adr_o sequence is 0x20..0x2F.
  - done_o in cycle 49.
  - Row 0: ver_p_o[0]=1, hor_p_o=0.
- Row 3 word 16'h0006:
  - ver_p_o=8'h02, ver_q_o=8'h02.
  - hor_vld_o=0, hor_p_o=0, hor_q_o=0.
- row_rdy_i low for 5 cycles on row 4:
  - Outputs stable throughout, no extra RAM reads.
  - Row 5 read issued the cycle after the handshake.
- start_i pulsed in cycles 10 and 49 of an active scan: both ignored; exactly 16 rows delivered.
- rst_n low in cycle 20:
  - All outputs at reset values.
  - A new start resumes from row 0 with a correct first row.
- With DB_CBF_AVAIL_EN, left_avail_i=0 and top_avail_i=0, left_cbf=16'hFFFF and top_cbf=16'hFFFF:
  - ver_p_o[0]=0 and ver_q_o[0]=0 on every row.
  - Row 0 hor_p_o=0 and hor_q_o=0.
